// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns ({g,f,e,d,c,b,a}) for the 7-segment scan driver.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/display bundle of the 7-segment scan driver; the driver sits on the slave side.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
) ();

    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  pending;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  frame;

    modport master (
        output load, bcd_in,
        input  pending, an, seg, frame
    );

    modport slave (
        input  load, bcd_in,
        output pending, an, seg, frame
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low segment decode; 10..15 render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t digit_i,
    output seg_t seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver with shadow register committed at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000
) (
    input logic              clk,
    input logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

    logic [CntW-1:0]   div_cnt_q, div_cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [BcdW-1:0]   shadow_q, shadow_d;
    logic [BcdW-1:0]   disp_q, disp_d;
    logic              pending_q, pending_d;
    logic [DIGITS-1:0] an_q, an_d;
    seg_t              seg_q, seg_d;
    logic              frame_q, frame_d;

    logic tick;
    logic commit;
    logic blank;
    bcd_t cur_digit;
    seg_t dec_seg;

    always_comb begin
        tick      = (div_cnt_q == CntMax);
        commit    = tick && (idx_q == IdxMax);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end

        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        // A load landing on the commit cycle bypasses the shadow entirely.
        if (commit) begin
            pending_d = 1'b0;
            if (bus.load) begin
                disp_d = bus.bcd_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end else if (bus.load) begin
            shadow_d  = bus.bcd_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_digit = bcd_t'(disp_q >> (4 * idx_q));
`ifdef SEG7_LZB_EN
        // Blank when this digit and everything above it is zero; digit 0 always shows.
        blank = (idx_q != '0) && ((disp_q >> (4 * idx_q)) == '0);
`else
        blank = 1'b0;
`endif
        an_d    = blank ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d   = blank ? SEG_OFF : dec_seg;
        frame_d = commit;
    end

    bcd_to_seg7 u_dec (
        .digit_i (cur_digit),
        .seg_o   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.pending = pending_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Random-stimulus bench for seg7_scan_driver against a cycle-count based reference model.
// Honours SEG7_LZB_EN when defined for the build.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int S  = 4;
    localparam int FP = D * S;

    logic clk = 1'b0;
    logic reset;

    seg7_scan_driver_if #(.DIGITS(D)) bus ();

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic bit ref_blank(input logic [15:0] v, input int dig);
`ifdef SEG7_LZB_EN
        return (dig != 0) && ((v >> (4 * dig)) == 16'h0);
`else
        return 1'b0 & v[0] & (dig == 0);
`endif
    endfunction

    // Model: position in the frame is plain arithmetic on cycles since reset.
    int          n = 0;
    bit          model_valid = 1'b0;
    logic [15:0] m_disp, m_shadow;
    bit          m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_frame, exp_pending;

    always @(posedge clk) begin
        int dig;
        bit commit;
        logic [15:0] sh;
        if (reset) begin
            n = 0;
            m_disp = '0;
            m_shadow = '0;
            m_pend = 1'b0;
            exp_an = 4'hF;
            exp_seg = 7'h7F;
            exp_frame = 1'b0;
            exp_pending = 1'b0;
            model_valid = 1'b1;
        end else begin
            dig = (n / S) % D;
            commit = (n % FP) == FP - 1;
            sh = m_disp >> (4 * dig);
            if (ref_blank(m_disp, dig)) begin
                exp_an = 4'hF;
                exp_seg = 7'h7F;
            end else begin
                exp_an = ~(4'b0001 << dig);
                exp_seg = ref_seg(sh[3:0]);
            end
            exp_frame = commit;
            if (commit) begin
                if (bus.load) m_disp = bus.bcd_in;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (bus.load) begin
                m_shadow = bus.bcd_in;
                m_pend = 1'b1;
            end
            exp_pending = m_pend;
            n++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_an", bus.an, exp_an);
            check("model_seg", bus.seg, exp_seg);
            check("model_frame", bus.frame, exp_frame);
            check("model_pending", bus.pending, exp_pending);
        end
    end

    logic [3:0] cap_an [D];
    logic [6:0] cap_seg [D];
    bit         cap_saw79;

    task automatic tick_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.bcd_in = v;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_frame();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FP + 2; i++) begin
            @(negedge clk);
            if (bus.frame) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_frame", 32'(found), 32'd1);
    endtask

    // Called right after a frame pulse: records mid-slot an/seg for every digit.
    task automatic capture();
        cap_saw79 = 1'b0;
        for (int i = 1; i <= FP; i++) begin
            @(negedge clk);
            if (bus.seg == 7'h79) cap_saw79 = 1'b1;
            if ((i - 1) % S == 1) begin
                cap_an[(i - 1) / S] = bus.an;
                cap_seg[(i - 1) / S] = bus.seg;
            end
        end
    endtask

    initial begin
        int f_cnt, f_pos0, f_pos1;
        logic [3:0] want_an;
        reset = 1'b1;
        bus.load = 1'b0;
        bus.bcd_in = '0;

        tick_n(3);
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_frame", bus.frame, 1'b0);
        check("rst_pending", bus.pending, 1'b0);
        reset = 1'b0;
        tick_n(1);
        check("first_an", bus.an, 4'b1110);
        check("first_seg", bus.seg, 7'h40);

        // Free-run: digit order and frame spacing.
        wait_frame();
        f_cnt = 0;
        f_pos0 = 0;
        f_pos1 = 0;
        for (int i = 1; i <= 2 * FP; i++) begin
            @(negedge clk);
            if (bus.frame) begin
                if (f_cnt == 0) f_pos0 = i;
                else f_pos1 = i;
                f_cnt++;
            end
            if (i <= FP) begin
                want_an = ~(4'b0001 << ((i - 1) / S));
                check("free_an", bus.an, want_an);
            end
        end
        check("free_frame_cnt", f_cnt, 2);
        check("free_frame_pos0", f_pos0, FP);
        check("free_frame_pos1", f_pos1, 2 * FP);

        // Mid-frame load waits for the commit.
        tick_n(3);
        pulse_load(16'h1234);
        check("p1234_pending", bus.pending, 1'b1);
        wait_frame();
        check("p1234_cleared", bus.pending, 1'b0);
        capture();
        check("d1234_0", cap_seg[0], 7'h19);
        check("d1234_1", cap_seg[1], 7'h30);
        check("d1234_2", cap_seg[2], 7'h24);
        check("d1234_3", cap_seg[3], 7'h79);
        check("d1234_an0", cap_an[0], 4'b1110);

        // Last load in a frame wins.
        tick_n(2);
        pulse_load(16'h1111);
        tick_n(3);
        pulse_load(16'h9876);
        wait_frame();
        capture();
        check("two_no79_a", 32'(cap_saw79), 32'd0);
        check("d9876_0", cap_seg[0], 7'h02);
        check("d9876_1", cap_seg[1], 7'h78);
        check("d9876_2", cap_seg[2], 7'h00);
        check("d9876_3", cap_seg[3], 7'h10);
        capture();
        check("two_no79_b", 32'(cap_saw79), 32'd0);

        // Non-decimal digit shows a dash.
        tick_n(3);
        pulse_load(16'h00A5);
        wait_frame();
        capture();
        check("a5_d0", cap_seg[0], 7'h12);
        check("a5_d1", cap_seg[1], 7'h3F);
`ifdef SEG7_LZB_EN
        check("a5_d2_blank_an", cap_an[2], 4'hF);
        check("a5_d2_blank_seg", cap_seg[2], 7'h7F);
        tick_n(3);
        pulse_load(16'h0042);
        wait_frame();
        capture();
        check("lzb42_d0", cap_seg[0], 7'h24);
        check("lzb42_d1", cap_seg[1], 7'h19);
        check("lzb42_an2", cap_an[2], 4'hF);
        check("lzb42_seg2", cap_seg[2], 7'h7F);
        check("lzb42_an3", cap_an[3], 4'hF);
        check("lzb42_seg3", cap_seg[3], 7'h7F);
        tick_n(3);
        pulse_load(16'h0000);
        wait_frame();
        capture();
        check("lzb0_an0", cap_an[0], 4'b1110);
        check("lzb0_seg0", cap_seg[0], 7'h40);
        check("lzb0_an1", cap_an[1], 4'hF);
        check("lzb0_seg3", cap_seg[3], 7'h7F);
`else
        check("a5_d2", cap_seg[2], 7'h40);
        check("a5_an3", cap_an[3], 4'b0111);
`endif

        // Load exactly on the commit cycle (capture ends on a frame pulse).
        tick_n(FP - 1);
        pulse_load(16'h5555);
        check("c5555_frame", bus.frame, 1'b1);
        check("c5555_pending", bus.pending, 1'b0);
        capture();
        check("c5555_d0", cap_seg[0], 7'h12);
        check("c5555_d3", cap_seg[3], 7'h12);

        // Reset drops a pending value.
        tick_n(3);
        pulse_load(16'h4321);
        check("rmid_pending", bus.pending, 1'b1);
        reset = 1'b1;
        tick_n(1);
        reset = 1'b0;
        check("rmid_pend0", bus.pending, 1'b0);
        check("rmid_an", bus.an, 4'hF);
        wait_frame();
        capture();
        check("rmid_d0", cap_seg[0], 7'h40);
        check("rmid_an0", cap_an[0], 4'b1110);
`ifdef SEG7_LZB_EN
        check("rmid_d3", cap_seg[3], 7'h7F);
`else
        check("rmid_d3", cap_seg[3], 7'h40);
`endif

        // Random loads and occasional resets, checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                tick_n(1);
                reset = 1'b0;
            end else if (r < 14) begin
                pulse_load(16'($urandom));
            end else if (r < 20) begin
                pulse_load({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
            end else begin
                tick_n(1);
            end
        end
        tick_n(2 * FP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
